polyvec_ntt_ctrl: RTL
=====================

// Module: polyvec_ntt_ctrl
// PURPOSE
//  Parametrised polyvec NTT sequencer: for each of KYBER_K polynomials, loads N coefficients from a packed source vector
//  into a scratch coefficient RAM, runs an external NTT engine then an external Barrett-reduce engine, and unloads the
//  result as packed words. Generalises the fixed K=2 enc/dec NTT stage to any K, coefficient widths and pack factor.
//  Sits between the Sp/Bp source buffers and the NTT-domain output BRAM in encryption and decryption.
// PARAMETERS
//  KYBER_K   2     polynomials per vector (2,3,4)
//  KYBER_N   256   coefficients per polynomial (power of 2)
//  SP_W      4     signed small-coefficient width (mode 0)
//  BP_W      12    unsigned coefficient width (mode 1)
//  CAL_W     16    scratch RAM / engine data width
//  OUT_W     12    output coefficient width
//  PACK      8     output coefficients per word (divides KYBER_N)
//  AW        $clog2(KYBER_N) ; PW = $clog2(KYBER_K) (min 1) ; OAW = $clog2(KYBER_K*KYBER_N/PACK)
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           begin vector (IDLE only)
//  mode       in   1           0 = enc (Sp source), 1 = dec (Bp source); sampled at start
//  src_rad    out  PW          polynomial index to source buffers
//  sp_rdata   in   SP_W*N      Sp polynomial, coeff i at [i*SP_W +: SP_W]; valid 1 cycle after src_rad
//  bp_rdata   in   BP_W*N      Bp polynomial, coeff i at [BP_W*N-1-i*BP_W -: BP_W]; valid 1 cycle after src_rad
//  ram_we     out  1           scratch RAM write enable
//  ram_wad    out  AW          scratch RAM write address
//  ram_wdata  out  CAL_W       scratch RAM write data
//  ram_rad    out  AW          scratch RAM read address
//  ram_rdata  in   CAL_W       scratch RAM read data, 1-cycle latency
//  ntt_start  out  1           1-cycle pulse to NTT engine
//  ntt_done   in   1           NTT engine completion pulse
//  red_start  out  1           1-cycle pulse to reduce engine
//  red_done   in   1           reduce engine completion pulse
//  eng_we/eng_wad/eng_wdata/eng_rad  in  1/AW/CAL_W/AW  active engine's RAM port, routed to ram_* in NTT/REDUCE
//  out_valid  out  1           output word strobe
//  out_wad    out  OAW         output word address = p*(N/PACK)+j
//  out_wdata  out  OUT_W*PACK  packed word, coeff j*PACK in MSBs
//  busy       out  1           high from cycle after start accept until done
//  done       out  1           1-cycle completion pulse
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; asynchronous, may occur in any state, no partial output after release.
//  FSM: IDLE -> SETTLE -> LOAD -> NTT -> REDUCE -> UNLOAD -> (SETTLE, p+1 | DONE) ; DONE -> IDLE.
//  IDLE: start=1 latches mode, p=0, src_rad=0, busy=1 next cycle. start ignored in every other state.
//  SETTLE: one wait cycle for source data.
//  LOAD: N cycles, cycle i: ram_we=1, ram_wad=i, ram_wdata = mode0 ? sign-extend(Sp coeff i) : zero-extend(Bp coeff i).
//  NTT: ntt_start pulses on entry cycle only; ram_* driven from eng_*; leave on ntt_done. REDUCE identical with red_*.
//  ntt_done/red_done outside their own state are ignored. Outside NTT/REDUCE ram_we comes only from LOAD.
//  UNLOAD: N+1 cycles, cycle i<N: ram_rad=i; coeff i = ram_rdata[OUT_W-1:0] captured cycle i+1;
//   capture of coeff j*PACK+PACK-1 registers out_wdata, out_valid=1 one cycle later (1 cycle per word, no backpressure).
//  After UNLOAD: p<K-1 -> p+1, src_rad=p+1, SETTLE; else DONE: done=1 one cycle, busy=0, src_rad=0.
//  Per polynomial: 1+N+NTT+REDUCE+N+1 cycles plus start pulses; exactly K*N/PACK out_valid per vector.
//  Counters wrap: coeff counter AW+1 bits; no wrap into next polynomial's addresses.
// TESTING
//  K=2, mode 0, all Sp coeffs 4'hF, stub engines (done after 5 cycles, no writes) -> 512 ram writes of 16'hFFFF; 64 words 96'hFFF..F, out_wad 0..63.
//  K=3, mode 1, Bp coeff i = i (poly p adds p*256 mod 3329), stub engines -> word 0 = {12'd0,12'd1,...,12'd7}; out_wad 0..95; one done.
//  start pulsed during NTT of p=0 -> ignored; exactly one done, busy stays 1 until then.
//  Spurious ntt_done during LOAD and red_done during NTT -> no state change; ntt_start/red_start each pulse once per poly.
//  rst_n low mid-UNLOAD of p=1 -> all outputs 0 immediately; fresh start then completes full vector correctly.
//  Engine model writing ram[i]=i+1 via eng_* -> unload reflects engine data, not loaded data.

Source files
------------

// File: rtl/polyvec_ntt_ctrl.sv
// Polyvec NTT sequencer: per polynomial, load packed source coefficients into scratch RAM, hand the
// RAM to external NTT and Barrett-reduce engines, then unload the result as packed output words.
module polyvec_ntt_ctrl #(
   parameter int KYBER_K = 2,
   parameter int KYBER_N = 256,
   parameter int SP_W    = 4,
   parameter int BP_W    = 12,
   parameter int CAL_W   = 16,
   parameter int OUT_W   = 12,
   parameter int PACK    = 8,
   parameter int AW      = $clog2(KYBER_N),
   parameter int PW      = (KYBER_K > 1) ? $clog2(KYBER_K) : 1,
   parameter int OAW     = $clog2(KYBER_K * KYBER_N / PACK)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      mode,
   output logic [PW-1:0]             src_rad,
   input  logic [SP_W*KYBER_N-1:0]   sp_rdata,
   input  logic [BP_W*KYBER_N-1:0]   bp_rdata,
   output logic                      ram_we,
   output logic [AW-1:0]             ram_wad,
   output logic [CAL_W-1:0]          ram_wdata,
   output logic [AW-1:0]             ram_rad,
   input  logic [CAL_W-1:0]          ram_rdata,
   output logic                      ntt_start,
   input  logic                      ntt_done,
   output logic                      red_start,
   input  logic                      red_done,
   input  logic                      eng_we,
   input  logic [AW-1:0]             eng_wad,
   input  logic [CAL_W-1:0]          eng_wdata,
   input  logic [AW-1:0]             eng_rad,
   output logic                      out_valid,
   output logic [OAW-1:0]            out_wad,
   output logic [OUT_W*PACK-1:0]     out_wdata,
   output logic                      busy,
   output logic                      done
);
   localparam int CW  = AW + 1;
   localparam int WW  = OUT_W * PACK;
   localparam int SPI = $clog2(SP_W * KYBER_N);
   localparam int BPI = $clog2(BP_W * KYBER_N);

   typedef enum logic [2:0] {IDLE, SETTLE, LOAD, NTT, REDUCE, UNLOAD, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [PW-1:0]           p;
   logic                    mode_r;
   logic [OAW-1:0]          wcnt;
   logic [WW-1:0]           word_p1;
   logic [WW-1:0]           word_nx;
   logic [WW-1:0]           coef_ext;
   logic [AW-1:0]           ci;
   logic [AW-1:0]           idx;
   logic [SPI-1:0]          sp_lsb;
   logic [BPI-1:0]          bp_msb;
   logic signed [SP_W-1:0]  sp_c;
   logic [BP_W-1:0]         bp_c;
   logic                    emit;
   logic                    unused_rdata;

   assign unused_rdata = ^ram_rdata[CAL_W-1:OUT_W];

   always_comb begin
      ci       = cnt[AW-1:0];
      idx      = ci - AW'(1);
      sp_lsb   = SPI'(ci) * SPI'(SP_W);
      bp_msb   = BPI'(BP_W * KYBER_N - 1) - BPI'(ci) * BPI'(BP_W);
      sp_c     = sp_rdata[sp_lsb +: SP_W];
      bp_c     = bp_rdata[bp_msb -: BP_W];
      coef_ext = '0;
      coef_ext[OUT_W-1:0] = ram_rdata[OUT_W-1:0];
      word_nx  = (word_p1 << OUT_W) | coef_ext;
      // Capture at count c holds coefficient c-1; a word closes on the last coefficient of each PACK group.
      emit     = (cnt != '0) && ((idx & AW'(PACK - 1)) == AW'(PACK - 1));
      ram_we    = 1'b0;
      ram_wad   = '0;
      ram_wdata = '0;
      ram_rad   = '0;
      case (state)
         LOAD: begin
            ram_we    = 1'b1;
            ram_wad   = ci;
            ram_wdata = mode_r ? {{(CAL_W - BP_W){1'b0}}, bp_c}
                               : {{(CAL_W - SP_W){sp_c[SP_W-1]}}, sp_c};
         end
         NTT, REDUCE: begin
            ram_we    = eng_we;
            ram_wad   = eng_wad;
            ram_wdata = eng_wdata;
            ram_rad   = eng_rad;
         end
         UNLOAD: begin
            if (cnt != CW'(KYBER_N)) ram_rad = ci;
         end
         default: ;
      endcase
   end

   // Stage p1: output word assembly
   always_ff @(posedge clk) begin
      if (state == UNLOAD && cnt != '0) word_p1 <= word_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         p         <= '0;
         mode_r    <= 1'b0;
         wcnt      <= '0;
         src_rad   <= '0;
         ntt_start <= 1'b0;
         red_start <= 1'b0;
         out_valid <= 1'b0;
         out_wad   <= '0;
         out_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ntt_start <= 1'b0;
         red_start <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_r  <= mode;
                  p       <= '0;
                  src_rad <= '0;
                  wcnt    <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               cnt   <= '0;
               state <= LOAD;
            end
            LOAD: begin
               if (cnt == CW'(KYBER_N - 1)) begin
                  cnt       <= '0;
                  ntt_start <= 1'b1;
                  state     <= NTT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            NTT: begin
               if (ntt_done) begin
                  red_start <= 1'b1;
                  state     <= REDUCE;
               end
            end
            REDUCE: begin
               if (red_done) begin
                  cnt   <= '0;
                  state <= UNLOAD;
               end
            end
            UNLOAD: begin
               if (emit) begin
                  out_wdata <= word_nx;
                  out_valid <= 1'b1;
                  out_wad   <= wcnt;
                  wcnt      <= wcnt + OAW'(1);
               end
               if (cnt == CW'(KYBER_N)) begin
                  cnt <= '0;
                  if (p == PW'(KYBER_K - 1)) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     src_rad <= '0;
                     state   <= DONE;
                  end else begin
                     p       <= p + PW'(1);
                     src_rad <= p + PW'(1);
                     state   <= SETTLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
